// File: rtl/scr1_tcm_pkg.sv
// Shared types for the DMEM TCM responder: memif enums, FSM states, LFSR constants, byte-enable helper.
package scr1_tcm_pkg;

    localparam int unsigned SCR1_DMEM_AWIDTH = 32;
    localparam int unsigned SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        SCR1_TCM_FSM_IDLE = 2'b00,
        SCR1_TCM_FSM_WAIT = 2'b01,
        SCR1_TCM_FSM_RESP = 2'b10
    } type_scr1_tcm_fsm_e;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
    localparam logic [7:0] SCR1_TCM_LFSR_SEED = 8'hA5;
    localparam logic [7:0] SCR1_TCM_LFSR_TAPS = 8'b1011_1000;

    function automatic logic [3:0] scr1_tcm_be(input type_scr1_mem_width_e width,
                                               input logic [1:0]           ofs);
        case (width)
            SCR1_MEM_WIDTH_BYTE:  return 4'b0001 << ofs;
            SCR1_MEM_WIDTH_HWORD: return 4'b0011 << ofs;
            SCR1_MEM_WIDTH_WORD:  return 4'b1111;
            default:              return '0;
        endcase
    endfunction

endpackage

// File: rtl/scr1_dmem_lane_align.sv
// Byte-lane steering between LSB-aligned core data and lane-positioned SRAM data.
module scr1_dmem_lane_align
    import scr1_tcm_pkg::*;
(
    input  type_scr1_mem_width_e width,
    input  logic [1:0]           wr_ofs,
    input  logic [31:0]          wdata,
    input  logic [1:0]           rd_ofs,
    input  logic [31:0]          rword,
    output logic [3:0]           be,
    output logic [31:0]          wdata_lane,
    output logic [31:0]          rdata_lsb
);

    assign be         = scr1_tcm_be(width, wr_ofs);
    assign wdata_lane = wdata << {wr_ofs, 3'b000};
    assign rdata_lsb  = rword >> {rd_ofs, 3'b000};

endmodule

// File: rtl/scr1_dmem_tcm_resp.sv
// DMEM req/ack/resp responder in front of a single-port synchronous TCM SRAM.
// Define SCR1_TCM_RAND_STALL_EN to withhold ack pseudo-randomly from an 8-bit LFSR.
module scr1_dmem_tcm_resp
    import scr1_tcm_pkg::*;
#(
    parameter logic [31:0] TCM_BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned TCM_SIZE_BYTES = 65536,
    parameter int unsigned WAIT_CYCLES    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 dmem2tcm_req_i,
    input  type_scr1_mem_cmd_e                   dmem2tcm_cmd_i,
    input  type_scr1_mem_width_e                 dmem2tcm_width_i,
    input  logic [SCR1_DMEM_AWIDTH-1:0]          dmem2tcm_addr_i,
    input  logic [SCR1_DMEM_DWIDTH-1:0]          dmem2tcm_wdata_i,
    output logic                                 tcm2dmem_req_ack_o,
    output logic [SCR1_DMEM_DWIDTH-1:0]          tcm2dmem_rdata_o,
    output type_scr1_mem_resp_e                  tcm2dmem_resp_o,
    output logic                                 tcm2ram_en_o,
    output logic                                 tcm2ram_we_o,
    output logic [3:0]                           tcm2ram_be_o,
    output logic [$clog2(TCM_SIZE_BYTES)-3:0]    tcm2ram_addr_o,
    output logic [31:0]                          tcm2ram_wdata_o,
    input  logic [31:0]                          ram2tcm_rdata_i
);

    localparam int unsigned RAM_AW = $clog2(TCM_SIZE_BYTES) - 2;
    localparam logic [31:0] SIZE_W = 32'(TCM_SIZE_BYTES);
    localparam logic [3:0]  WAIT_W = 4'(WAIT_CYCLES);
    localparam type_scr1_tcm_fsm_e ST_AFTER_ACC =
        (WAIT_CYCLES == 0) ? SCR1_TCM_FSM_RESP : SCR1_TCM_FSM_WAIT;

    type_scr1_tcm_fsm_e state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        rdata_q;
    logic               err_q, rd_q;
    logic [1:0]         ofs_q;

    logic               stall, ack, accept, err, misalign, ram_en;
    logic [31:0]        offset, rword, rdata_lsb, wdata_lane;
    logic [3:0]         be_raw;

`ifdef SCR1_TCM_RAND_STALL_EN
    logic [7:0] lfsr_q;
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= SCR1_TCM_LFSR_SEED;
        else     lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & SCR1_TCM_LFSR_TAPS)};
    end
    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    assign ack      = ((state_q == SCR1_TCM_FSM_IDLE) | (state_q == SCR1_TCM_FSM_RESP)) & ~stall & ~rst;
    assign accept   = dmem2tcm_req_i & ack;
    // Subtraction wraps modulo 2^32, so addresses below base land far out of range
    assign offset   = dmem2tcm_addr_i - TCM_BASE_ADDR;
    assign misalign = ((dmem2tcm_width_i == SCR1_MEM_WIDTH_HWORD) & dmem2tcm_addr_i[0])
                    | ((dmem2tcm_width_i == SCR1_MEM_WIDTH_WORD)  & (dmem2tcm_addr_i[1:0] != 2'b00));
    assign err      = misalign | (offset >= SIZE_W);
    assign ram_en   = accept & ~err;

    assign rword = (WAIT_CYCLES == 0) ? ram2tcm_rdata_i : rdata_q;

    scr1_dmem_lane_align u_lane_align (
        .width      (dmem2tcm_width_i),
        .wr_ofs     (dmem2tcm_addr_i[1:0]),
        .wdata      (dmem2tcm_wdata_i),
        .rd_ofs     (ofs_q),
        .rword      (rword),
        .be         (be_raw),
        .wdata_lane (wdata_lane),
        .rdata_lsb  (rdata_lsb)
    );

    assign tcm2dmem_req_ack_o = ack;
    assign tcm2ram_en_o       = ram_en;
    assign tcm2ram_we_o       = ram_en & (dmem2tcm_cmd_i == SCR1_MEM_CMD_WR);
    assign tcm2ram_be_o       = ram_en ? be_raw : '0;
    assign tcm2ram_addr_o     = ram_en ? offset[RAM_AW+1:2] : '0;
    assign tcm2ram_wdata_o    = ram_en ? wdata_lane : '0;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        tcm2dmem_resp_o  = SCR1_MEM_RESP_NOTRDY;
        tcm2dmem_rdata_o = '0;
        case (state_q)
            SCR1_TCM_FSM_IDLE: begin
                if (accept) state_d = ST_AFTER_ACC;
            end
            SCR1_TCM_FSM_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = SCR1_TCM_FSM_RESP;
            end
            SCR1_TCM_FSM_RESP: begin
                tcm2dmem_resp_o  = err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                tcm2dmem_rdata_o = (rd_q & ~err_q) ? rdata_lsb : '0;
                state_d          = accept ? ST_AFTER_ACC : SCR1_TCM_FSM_IDLE;
            end
            default: state_d = SCR1_TCM_FSM_IDLE;
        endcase
        if (accept) cnt_d = WAIT_W;
        if (rst) begin
            tcm2dmem_resp_o  = SCR1_MEM_RESP_NOTRDY;
            tcm2dmem_rdata_o = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCR1_TCM_FSM_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            ofs_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                err_q <= err;
                rd_q  <= (dmem2tcm_cmd_i == SCR1_MEM_CMD_RD);
                ofs_q <= dmem2tcm_addr_i[1:0];
            end
            // SRAM output is only valid the cycle after the access, i.e. the first WAIT cycle
            if ((state_q == SCR1_TCM_FSM_WAIT) && (cnt_q == WAIT_W)) rdata_q <= ram2tcm_rdata_i;
        end
    end

endmodule

// File: tb/tb_scr1_dmem_tcm_resp.sv
// Directed bench: one responder with zero wait states, one with three wait states and an offset window.
module tb_scr1_dmem_tcm_resp;
    import scr1_tcm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 req   [2];
    type_scr1_mem_cmd_e   cmd   [2];
    type_scr1_mem_width_e width [2];
    logic [31:0]          addr  [2];
    logic [31:0]          wdata [2];
    logic                 ack   [2];
    logic [31:0]          rdata [2];
    type_scr1_mem_resp_e  resp  [2];
    logic                 en    [2];
    logic                 we    [2];
    logic [3:0]           be    [2];
    logic [31:0]          wd    [2];
    logic [15:0]          raddr [2];
    logic [13:0]          raddr0;
    logic [9:0]           raddr3;
    logic [31:0]          rram0, rram3;

    assign raddr[0] = 16'(raddr0);
    assign raddr[1] = 16'(raddr3);

    scr1_dmem_tcm_resp #(.TCM_BASE_ADDR(32'h0), .TCM_SIZE_BYTES(65536), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .dmem2tcm_req_i(req[0]), .dmem2tcm_cmd_i(cmd[0]),
        .dmem2tcm_width_i(width[0]), .dmem2tcm_addr_i(addr[0]), .dmem2tcm_wdata_i(wdata[0]),
        .tcm2dmem_req_ack_o(ack[0]), .tcm2dmem_rdata_o(rdata[0]), .tcm2dmem_resp_o(resp[0]),
        .tcm2ram_en_o(en[0]), .tcm2ram_we_o(we[0]), .tcm2ram_be_o(be[0]),
        .tcm2ram_addr_o(raddr0), .tcm2ram_wdata_o(wd[0]), .ram2tcm_rdata_i(rram0));

    scr1_dmem_tcm_resp #(.TCM_BASE_ADDR(32'h1000), .TCM_SIZE_BYTES(4096), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .dmem2tcm_req_i(req[1]), .dmem2tcm_cmd_i(cmd[1]),
        .dmem2tcm_width_i(width[1]), .dmem2tcm_addr_i(addr[1]), .dmem2tcm_wdata_i(wdata[1]),
        .tcm2dmem_req_ack_o(ack[1]), .tcm2dmem_rdata_o(rdata[1]), .tcm2dmem_resp_o(resp[1]),
        .tcm2ram_en_o(en[1]), .tcm2ram_we_o(we[1]), .tcm2ram_be_o(be[1]),
        .tcm2ram_addr_o(raddr3), .tcm2ram_wdata_o(wd[1]), .ram2tcm_rdata_i(rram3));

    // External SRAM models
    logic [31:0] sram0 [16384];
    logic [31:0] sram3 [1024];
    always @(posedge clk) begin
        if (en[0]) begin
            if (we[0]) begin
                for (int b = 0; b < 4; b++) if (be[0][b]) sram0[raddr0][8*b +: 8] <= wd[0][8*b +: 8];
            end else rram0 <= sram0[raddr0];
        end
    end
    always @(posedge clk) begin
        if (en[1]) begin
            if (we[1]) begin
                for (int b = 0; b < 4; b++) if (be[1][b]) sram3[raddr3][8*b +: 8] <= wd[1][8*b +: 8];
            end else rram3 <= sram3[raddr3];
        end
    end

    typedef struct {
        type_scr1_mem_cmd_e   cmd;
        type_scr1_mem_width_e width;
        logic [31:0]          addr;
        logic [31:0]          wdata;
        logic                 exp_en;
        logic [3:0]           exp_be;
        logic [31:0]          exp_wlane;
        type_scr1_mem_resp_e  exp_resp;
        logic [31:0]          exp_rdata;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned stall_cnt = 0;
    logic [31:0] ref_mem [16384];
    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                                   input logic [31:0] a, input logic [31:0] d);
        vec_t v;
        logic bad;
        logic [1:0] lo;
        lo = a[1:0];
        v.cmd = c; v.width = w; v.addr = a; v.wdata = d;
        bad = ((w == SCR1_MEM_WIDTH_HWORD) && lo[0]) || ((w == SCR1_MEM_WIDTH_WORD) && (lo != 2'b00))
              || (a >= 32'h10000);
        v.exp_en = !bad;
        case (w)
            SCR1_MEM_WIDTH_BYTE:  v.exp_be = 4'b0001 << lo;
            SCR1_MEM_WIDTH_HWORD: v.exp_be = 4'b0011 << lo;
            default:              v.exp_be = 4'b1111;
        endcase
        v.exp_wlane = d << (8 * lo);
        v.exp_resp  = bad ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        v.exp_rdata = (bad || (c == SCR1_MEM_CMD_WR)) ? 32'h0 : (ref_mem[a[15:2]] >> (8 * lo));
        return v;
    endfunction

    task automatic do_xact(input int unsigned d, input vec_t v);
        int unsigned n, lat, exp_lat;
        logic [31:0] base;
        exp_lat = (d == 0) ? 1 : 4;
        base    = (d == 0) ? 32'h0 : 32'h1000;
        @(negedge clk);
        req[d] = 1'b1; cmd[d] = v.cmd; width[d] = v.width; addr[d] = v.addr; wdata[d] = v.wdata;
        #1;
        n = 0;
        while (!ack[d] && n < 64) begin
            @(negedge clk); #1; n++;
        end
        stall_cnt += n;
        if (!ack[d]) begin
            n_checks++; n_err++;
            $display("FAIL ack_timeout: ack still 0 after %0d cycles, expected 1", n);
            req[d] = 1'b0;
            return;
        end
`ifndef SCR1_TCM_RAND_STALL_EN
        chk("ack_wait", n, 0);
`endif
        chk("ram_en", en[d], v.exp_en);
        chk("ram_we", we[d], v.exp_en & (v.cmd == SCR1_MEM_CMD_WR));
        chk("ram_be", be[d], v.exp_en ? v.exp_be : 4'h0);
        chk("ram_wdata", wd[d], v.exp_en ? v.exp_wlane : 32'h0);
        chk("ram_addr", raddr[d], v.exp_en ? ((v.addr - base) >> 2) : 32'h0);
        if (d == 0 && v.exp_en && v.cmd == SCR1_MEM_CMD_WR)
            for (int b = 0; b < 4; b++)
                if (v.exp_be[b]) ref_mem[v.addr[15:2]][8*b +: 8] = v.exp_wlane[8*b +: 8];
        @(posedge clk); #1;
        req[d] = 1'b0;
        @(negedge clk); #1;
        lat = 1;
        while (resp[d] == SCR1_MEM_RESP_NOTRDY && lat < 32) begin
            @(negedge clk); #1; lat++;
        end
        chk("resp_latency", lat, exp_lat);
        chk("resp", resp[d], v.exp_resp);
        chk("rdata", rdata[d], v.exp_rdata);
        @(negedge clk); #1;
        chk("resp_one_cycle", resp[d], SCR1_MEM_RESP_NOTRDY);
    endtask

    initial begin
        for (int unsigned i = 0; i < 2; i++) begin
            req[i] = 1'b0; cmd[i] = SCR1_MEM_CMD_RD; width[i] = SCR1_MEM_WIDTH_WORD;
            addr[i] = '0; wdata[i] = '0;
        end
        vecs[0]  = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h10,    32'hDEADBEEF, 1'b1, 4'hF, 32'hDEADBEEF, SCR1_MEM_RESP_RDY_OK, 32'h0};
        vecs[1]  = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h10,    32'h0,        1'b1, 4'hF, 32'h0,        SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF};
        vecs[2]  = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h13,    32'h0,        1'b1, 4'h8, 32'h0,        SCR1_MEM_RESP_RDY_OK, 32'h000000DE};
        vecs[3]  = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE,  32'h13,    32'h5A,       1'b1, 4'h8, 32'h5A000000, SCR1_MEM_RESP_RDY_OK, 32'h0};
        vecs[4]  = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h13,    32'h0,        1'b1, 4'h8, 32'h0,        SCR1_MEM_RESP_RDY_OK, 32'h0000005A};
        vecs[5]  = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h12,    32'h0,        1'b1, 4'hC, 32'h0,        SCR1_MEM_RESP_RDY_OK, 32'h00005AAD};
        vecs[6]  = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h11,    32'h0,        1'b0, 4'h0, 32'h0,        SCR1_MEM_RESP_RDY_ER, 32'h0};
        vecs[7]  = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h10000, 32'h0,        1'b0, 4'h0, 32'h0,        SCR1_MEM_RESP_RDY_ER, 32'h0};
        vecs[8]  = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h12,    32'h12345678, 1'b0, 4'h0, 32'h0,        SCR1_MEM_RESP_RDY_ER, 32'h0};
        vecs[9]  = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h22,    32'h1234ABCD, 1'b1, 4'hC, 32'hABCD0000, SCR1_MEM_RESP_RDY_OK, 32'h0};
        vecs[10] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h20,    32'h0,        1'b1, 4'hF, 32'h0,        SCR1_MEM_RESP_RDY_OK, 32'hABCD0000};
        vecs[11] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h21,    32'h0,        1'b1, 4'h2, 32'h0,        SCR1_MEM_RESP_RDY_OK, 32'h00ABCD00};
        vecs[12] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'hFFFC,  32'h11223344, 1'b1, 4'hF, 32'h11223344, SCR1_MEM_RESP_RDY_OK, 32'h0};
        vecs[13] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE,  32'hFFFF,  32'h77,       1'b1, 4'h8, 32'h77000000, SCR1_MEM_RESP_RDY_OK, 32'h0};
        vecs[14] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'hFFFC,  32'h0,        1'b1, 4'hF, 32'h0,        SCR1_MEM_RESP_RDY_OK, 32'h77223344};
        vecs[15] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'hFFFE,  32'h0,        1'b1, 4'hC, 32'h0,        SCR1_MEM_RESP_RDY_OK, 32'h00007722};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int unsigned i = 0; i < 2; i++) begin
            chk("rst_ack", ack[i], 1'b0);
            chk("rst_ram_en", en[i], 1'b0);
            chk("rst_resp", resp[i], SCR1_MEM_RESP_NOTRDY);
            chk("rst_rdata", rdata[i], 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_resp", resp[0], SCR1_MEM_RESP_NOTRDY);
`ifndef SCR1_TCM_RAND_STALL_EN
        chk("idle_ack", ack[0], 1'b1);
`endif

        // Clear the low window so later reads have defined contents
        for (int unsigned i = 0; i < 64; i++) do_xact(0, model(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, i * 4, 32'h0));
        for (int unsigned i = 0; i < 16; i++) do_xact(0, vecs[i]);

        for (int unsigned i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? (32'h10000 + $urandom_range(0, 255)) : 32'($urandom_range(0, 255));
            do_xact(0, model(type_scr1_mem_cmd_e'($urandom_range(0, 1)),
                             type_scr1_mem_width_e'($urandom_range(0, 2)), a, $urandom));
        end

        // Three wait states, window 0x1000..0x1FFF
        do_xact(1, '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h1004, 32'hCAFEF00D, 1'b1, 4'hF, 32'hCAFEF00D, SCR1_MEM_RESP_RDY_OK, 32'h0});
        do_xact(1, '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h1004, 32'h0, 1'b1, 4'hF, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'hCAFEF00D});
        do_xact(1, '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h1006, 32'h0, 1'b1, 4'h4, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h0000CAFE});
        do_xact(1, '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0FFC, 32'h0, 1'b0, 4'h0, 32'h0, SCR1_MEM_RESP_RDY_ER, 32'h0});
        do_xact(1, '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h2000, 32'h0, 1'b0, 4'h0, 32'h0, SCR1_MEM_RESP_RDY_ER, 32'h0});

`ifndef SCR1_TCM_RAND_STALL_EN
        // Back-to-back: second request held high, acked only in the RESP cycle
        @(negedge clk);
        req[1] = 1'b1; cmd[1] = SCR1_MEM_CMD_RD; width[1] = SCR1_MEM_WIDTH_WORD; addr[1] = 32'h1004;
        #1 chk("b2b_ack_first", ack[1], 1'b1);
        @(posedge clk); #1;
        width[1] = SCR1_MEM_WIDTH_BYTE; addr[1] = 32'h1007;
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("b2b_ack_wait", ack[1], 1'b0);
            chk("b2b_resp_wait", resp[1], SCR1_MEM_RESP_NOTRDY);
        end
        @(negedge clk); #1;
        chk("b2b_ack_resp", ack[1], 1'b1);
        chk("b2b_resp1", resp[1], SCR1_MEM_RESP_RDY_OK);
        chk("b2b_rdata1", rdata[1], 32'hCAFEF00D);
        @(posedge clk); #1;
        req[1] = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("b2b_resp2_wait", resp[1], SCR1_MEM_RESP_NOTRDY);
        end
        @(negedge clk); #1;
        chk("b2b_resp2", resp[1], SCR1_MEM_RESP_RDY_OK);
        chk("b2b_rdata2", rdata[1], 32'h000000CA);
        @(negedge clk); #1;
        chk("b2b_resp2_one_cycle", resp[1], SCR1_MEM_RESP_NOTRDY);

        // Reset while in WAIT drops the in-flight response
        @(negedge clk);
        req[1] = 1'b1; cmd[1] = SCR1_MEM_CMD_RD; width[1] = SCR1_MEM_WIDTH_WORD; addr[1] = 32'h1004;
        #1 chk("rstw_ack", ack[1], 1'b1);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1; req[1] = 1'b1;
        #1;
        chk("rstw_ack_in_rst", ack[1], 1'b0);
        chk("rstw_en_in_rst", en[1], 1'b0);
        chk("rstw_resp_in_rst", resp[1], SCR1_MEM_RESP_NOTRDY);
        for (int unsigned k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("rstw_ack_hold", ack[1], 1'b0);
            chk("rstw_resp_hold", resp[1], SCR1_MEM_RESP_NOTRDY);
        end
        @(negedge clk);
        rst = 1'b0; req[1] = 1'b0;
        #1;
        chk("rstw_resp_after", resp[1], SCR1_MEM_RESP_NOTRDY);
        chk("rstw_ack_after", ack[1], 1'b1);
        do_xact(1, '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h1004, 32'h0, 1'b1, 4'hF, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'hCAFEF00D});
`else
        $display("ack withheld for %0d request cycles", stall_cnt);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
